// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: register offsets, handshake FSM encoding and
// the byte-strobe merge helper used by every writable register.
package clint_timer_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the wrap cycle with a tick.
module clint_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  // With PRESCALE=1 the counter is pinned at 0 and tick stays high.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Machine-mode CLINT: msip, mtimecmp and mtime behind a single-outstanding
// request/response port, plus the software and timer interrupt lines.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int REG_WIDTH = 64,
  parameter int PRESCALE  = 1
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [15:0]            req_addr_i,
  input  logic [REG_WIDTH-1:0]   req_wdata_i,
  input  logic [REG_WIDTH/8-1:0] req_wstrb_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [REG_WIDTH-1:0]   resp_rdata_o,
  output logic                   resp_err_o,
  output logic                   software_intr_o,
  output logic                   time_intr_o,
  output logic [REG_WIDTH-1:0]   mtime_o
);

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; the response transfers on an edge where
  // resp_valid_o and resp_ready_i are both high. Only one request is ever
  // outstanding, so req_ready_o is low for the whole response phase.

  state_t               state;
  state_t               state_next;
  logic [REG_WIDTH-1:0] mtime;
  logic [REG_WIDTH-1:0] mtimecmp;
  logic                 msip;
  logic                 tick;
  logic                 accept;
  logic                 wr;
  logic                 hit_msip;
  logic                 hit_cmp;
  logic                 hit_time;
  logic                 mapped;
  logic [REG_WIDTH-1:0] rd_data;

  clint_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk_sys_i (clk_sys_i),
    .rst_sys_i (rst_sys_i),
    .tick      (tick)
  );

  assign accept   = (state == ST_IDLE) && req_valid_i;
  assign wr       = accept && req_we_i;
  assign hit_msip = (req_addr_i == MSIP_OFF);
  assign hit_cmp  = (req_addr_i == MTIMECMP_OFF);
  assign hit_time = (req_addr_i == MTIME_OFF);
  assign mapped   = hit_msip || hit_cmp || hit_time;

  always_comb begin
    state_next   = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (hit_msip)      rd_data = {{(REG_WIDTH-1){1'b0}}, msip};
    else if (hit_cmp)  rd_data = mtimecmp;
    else if (hit_time) rd_data = mtime;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state        <= ST_IDLE;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        resp_rdata_o <= req_we_i ? '0 : rd_data;
        resp_err_o   <= !mapped;
      end
    end
  end

  // A bus write to mtime wins over the tick; that increment is simply lost.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      msip        <= 1'b0;
      time_intr_o <= 1'b0;
    end else begin
      if (wr && hit_time) mtime <= merge_bytes(mtime, req_wdata_i, req_wstrb_i);
      else if (tick)      mtime <= mtime + 64'd1;
      if (wr && hit_cmp)  mtimecmp <= merge_bytes(mtimecmp, req_wdata_i, req_wstrb_i);
      if (wr && hit_msip && req_wstrb_i[0]) msip <= req_wdata_i[0];
      time_intr_o <= (mtime >= mtimecmp);
    end
  end

  assign software_intr_o = msip;
  assign mtime_o         = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: register table plus hand-written timing
// sequences for counter wrap, interrupt latency, stalls and mid-response reset.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        sw_intr;
  logic        tm_intr;
  logic [63:0] mtime;

  logic        p3_req_valid = 1'b0;
  logic        p3_req_ready;
  logic        p3_req_we = 1'b0;
  logic [15:0] p3_req_addr = '0;
  logic [63:0] p3_req_wdata = '0;
  logic [7:0]  p3_req_wstrb = '0;
  logic        p3_resp_valid;
  logic        p3_resp_ready = 1'b1;
  logic [63:0] p3_resp_rdata;
  logic        p3_resp_err;
  logic        p3_sw_intr;
  logic        p3_tm_intr;
  logic [63:0] p3_mtime;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clint_timer dut (
    .clk_sys_i       (clk),
    .rst_sys_i       (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .req_wstrb_i     (req_wstrb),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_rdata_o    (resp_rdata),
    .resp_err_o      (resp_err),
    .software_intr_o (sw_intr),
    .time_intr_o     (tm_intr),
    .mtime_o         (mtime)
  );

  clint_timer #(.PRESCALE(3)) dut_p3 (
    .clk_sys_i       (clk),
    .rst_sys_i       (rst),
    .req_valid_i     (p3_req_valid),
    .req_ready_o     (p3_req_ready),
    .req_we_i        (p3_req_we),
    .req_addr_i      (p3_req_addr),
    .req_wdata_i     (p3_req_wdata),
    .req_wstrb_i     (p3_req_wstrb),
    .resp_valid_o    (p3_resp_valid),
    .resp_ready_i    (p3_resp_ready),
    .resp_rdata_o    (p3_resp_rdata),
    .resp_err_o      (p3_resp_err),
    .software_intr_o (p3_sw_intr),
    .time_intr_o     (p3_tm_intr),
    .mtime_o         (p3_mtime)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        exp_err;
    logic        chk_rd;
    logic [63:0] exp_rdata;
    logic        exp_sw;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue_req(input logic we, input logic [15:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wstrb);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_before_issue", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("resp_valid_latency", {63'b0, resp_valid}, 64'd1);
  endtask

  task automatic finish_resp(output logic [63:0] rdata, output logic err);
    rdata      = resp_rdata;
    err        = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          guard;

    vecs[0]  = '{1'b1, 16'h0000, 64'h0000_0000_0000_00FF, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[1]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 1'b0, 1'b1, 64'h1, 1'b1};
    vecs[2]  = '{1'b1, 16'h0000, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0, 1'b0};
    vecs[4]  = '{1'b1, 16'h0000, 64'h1, 8'hFE, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[5]  = '{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[6]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 1'b0, 1'b1, 64'hFFFF_FFFF_5566_7788, 1'b0};
    vecs[7]  = '{1'b1, 16'h4000, 64'hAABB_CCDD_0000_0000, 8'hF0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[8]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 1'b0, 1'b1, 64'hAABB_CCDD_5566_7788, 1'b0};
    vecs[9]  = '{1'b0, 16'h1234, 64'h0, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0};
    vecs[10] = '{1'b1, 16'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1'b1, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 16'h4004, 64'h0, 8'h00, 1'b1, 1'b1, 64'h0, 1'b0};
    vecs[12] = '{1'b0, 16'h4000, 64'h0, 8'h00, 1'b0, 1'b1, 64'hAABB_CCDD_5566_7788, 1'b0};
    vecs[13] = '{1'b1, 16'h0000, 64'h1, 8'h01, 1'b0, 1'b0, 64'h0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mtime", mtime, 64'd0);
    check("rst_time_intr", {63'b0, tm_intr}, 64'd0);
    check("rst_sw_intr", {63'b0, sw_intr}, 64'd0);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_req_ready", {63'b0, req_ready}, 64'd1);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", {63'b0, resp_err}, 64'd0);
    rst = 1'b0;

    // Free run for 10 cycles
    repeat (10) @(negedge clk);
    check("idle10_mtime", mtime, 64'd10);
    check("idle10_time_intr", {63'b0, tm_intr}, 64'd0);
    check("idle10_p3_mtime", p3_mtime, 64'd3);

    // Register table
    for (int i = 0; i < 14; i++) begin
      issue_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      finish_resp(rd, er);
      check($sformatf("vec%0d_err", i), {63'b0, er}, {63'b0, vecs[i].exp_err});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_sw_intr", i), {63'b0, sw_intr}, {63'b0, vecs[i].exp_sw});
    end

    // Timer interrupt rise and fall
    issue_req(1'b1, 16'hBFF8, 64'h0, 8'hFF);
    finish_resp(rd, er);
    issue_req(1'b1, 16'h4000, 64'h20, 8'hFF);
    finish_resp(rd, er);
    guard = 0;
    while (mtime != 64'h20 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cmp_reach_0x20", mtime, 64'h20);
    check("tintr_still_low", {63'b0, tm_intr}, 64'd0);
    @(negedge clk);
    check("tintr_rise", {63'b0, tm_intr}, 64'd1);
    issue_req(1'b1, 16'h4000, 64'hFFFF, 8'hFF);
    check("tintr_held_after_write", {63'b0, tm_intr}, 64'd1);
    finish_resp(rd, er);
    check("tintr_fall", {63'b0, tm_intr}, 64'd0);

    // mtime wrap, write beats same-cycle tick
    issue_req(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    check("wrap_written", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("wrap_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("wrap_zero", mtime, 64'h0);
    finish_resp(rd, er);

    // Read returns value before the same-cycle increment
    issue_req(1'b1, 16'hBFF8, 64'h100, 8'hFF);
    finish_resp(rd, er);
    issue_req(1'b0, 16'hBFF8, 64'h0, 8'h00);
    finish_resp(rd, er);
    check("mtime_read_pre_inc", rd, 64'h101);

    // Unmapped read with stalled consumer
    issue_req(1'b0, 16'h1234, 64'h0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_resp_valid", k), {63'b0, resp_valid}, 64'd1);
      check($sformatf("stall%0d_req_ready", k), {63'b0, req_ready}, 64'd0);
      check($sformatf("stall%0d_err", k), {63'b0, resp_err}, 64'd1);
      check($sformatf("stall%0d_rdata", k), resp_rdata, 64'd0);
      @(negedge clk);
    end
    finish_resp(rd, er);
    check("stall_released_ready", {63'b0, req_ready}, 64'd1);

    // Reset while a response is pending
    issue_req(1'b0, 16'h0000, 64'h0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("midrst_req_ready", {63'b0, req_ready}, 64'd1);
    check("midrst_rdata", resp_rdata, 64'd0);
    check("midrst_sw_intr", {63'b0, sw_intr}, 64'd0);
    check("midrst_mtime", mtime, 64'd0);
    rst = 1'b0;
    issue_req(1'b0, 16'h4000, 64'h0, 8'h00);
    finish_resp(rd, er);
    check("midrst_cmp_ones", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check("midrst_cmp_err", {63'b0, er}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, the data and counter width, fixed at 64 for this block.
REQ-002 SHALL have parameter PRESCALE, default 1, the number of clk_sys_i cycles per mtime increment, legal range 1..65535.
REQ-003 SHALL have port clk_sys_i  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port rst_sys_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  1  bus request valid.
REQ-006 SHALL have port req_ready_o  output  1  block can accept a request.
REQ-007 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  input  16  byte offset inside the CLINT window.
REQ-009 SHALL have port req_wdata_i  input  REG_WIDTH  write data.
REQ-010 SHALL have port req_wstrb_i  input  REG_WIDTH/8  byte write enables.
REQ-011 SHALL have port resp_valid_o  output  1  response valid.
REQ-012 SHALL have port resp_ready_i  input  1  consumer accepts the response.
REQ-013 SHALL have port resp_rdata_o  output  REG_WIDTH  read data.
REQ-014 SHALL have port resp_err_o  output  1  unmapped-address error.
REQ-015 SHALL have port software_intr_o  output  1  machine software interrupt, feeds the Memory stage software_intr_o path.
REQ-016 SHALL have port time_intr_o  output  1  machine timer interrupt, feeds the Memory stage time_intr_o path.
REQ-017 SHALL have port mtime_o  output  REG_WIDTH  current mtime value, used by the CSR time/cycle shadow.

Function
REQ-018 SHALL map msip at 0x0000 (only bit 0 is implemented; other bits read 0), mtimecmp at 0x4000, and mtime at 0xBFF8; all three are 64-bit and addressed on 8-byte-aligned offsets.
REQ-019 SHALL implement a two-state handshake FSM: IDLE (req_ready_o=1) and RESP (req_ready_o=0, resp_valid_o=1).
REQ-020 SHALL accept a request in IDLE when req_valid_i=1 and enter RESP on the next cycle, giving a response latency of exactly 1 cycle.
REQ-021 SHALL leave RESP for IDLE on the cycle in which resp_ready_i=1, and hold resp_rdata_o and resp_err_o stable while in RESP.
REQ-022 SHALL perform a write on the acceptance cycle, updating only the bytes whose req_wstrb_i bit is 1.
REQ-023 SHALL capture read data from the register value before any same-cycle increment.
REQ-024 SHALL treat any other offset as unmapped: resp_err_o=1, resp_rdata_o=0, no state change.
REQ-025 SHALL use a prescaler counter that runs 0..PRESCALE-1 and emits a one-cycle tick on wrap; PRESCALE=1 gives a tick every cycle.
REQ-026 SHALL increment mtime by 1 on each tick, wrapping from 2^64-1 to 0.
REQ-027 SHALL, when a bus write to mtime coincides with a tick, store the written bytes and drop that cycle's increment; the prescaler is unaffected.
REQ-028 SHALL register time_intr_o as (mtime >= mtimecmp, unsigned), one cycle after the registers change, so it clears one cycle after mtimecmp is written above mtime.
REQ-029 SHALL drive software_intr_o directly from msip bit 0 (registered, no extra latency).
REQ-030 SHALL drive mtime_o directly from the mtime register.

Reset
REQ-031 SHALL, on reset, clear mtime, msip and the prescaler to 0, set mtimecmp to all-ones, and clear time_intr_o, software_intr_o, resp_valid_o, resp_rdata_o and resp_err_o to 0; the FSM enters IDLE with req_ready_o=1 in the cycle after reset.
REQ-032 SHALL, on reset asserted mid-transaction, drop the pending response without any write-back; reset has priority over all other events.

Structure
REQ-033 SHALL place the address offsets MSIP_OFF, MTIMECMP_OFF and MTIME_OFF, plus the FSM state encoding, in the shared QianTang header/package.
REQ-034 SHALL implement the prescaler as sub-module clint_tick_gen (parameter PRESCALE, output tick); the register file and FSM remain in clint_timer.

Verification
REQ-035 SHALL cover: reset, then idle 10 cycles with PRESCALE=1 -> mtime_o=10, time_intr_o=0.
REQ-036 SHALL cover: write mtimecmp=0x20 with wstrb=0xFF -> time_intr_o rises 1 cycle after mtime_o reaches 0x20; then write mtimecmp=0xFFFF -> time_intr_o falls 1 cycle later.
REQ-037 SHALL cover: write mtime=0xFFFF_FFFF_FFFF_FFFE with PRESCALE=1 -> mtime_o goes 0xFFFF_FFFF_FFFF_FFFF then 0x0 on successive cycles.
REQ-038 SHALL cover: write msip=0x1, then 0x0 -> software_intr_o 1 then 0; a read of msip after writing 0xFF returns 0x1.
REQ-039 SHALL cover: read at offset 0x1234 -> resp_err_o=1, rdata=0; hold resp_ready_i=0 for 3 cycles -> resp_valid_o stays 1 and req_ready_o stays 0.
REQ-040 SHALL cover: write mtimecmp with wstrb=0x0F and data 0x1122334455667788 -> mtimecmp reads 0xFFFFFFFF55667788; assert reset during RESP -> resp_valid_o=0 next cycle.
